// File: rtl/id_pkg.sv
// Shared decode definitions for the ARM-subset ID stage:
// control-bundle layout, cond/mode/opcode codes and decode helpers.
package id_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_WB_EN  = 8;
  localparam int CTRL_MEM_R  = 7;
  localparam int CTRL_MEM_W  = 6;
  localparam int CTRL_EXE_HI = 5;
  localparam int CTRL_EXE_LO = 2;
  localparam int CTRL_B      = 1;
  localparam int CTRL_S      = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_MEM   = 2'b01;
  localparam logic [1:0] MODE_BR    = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  function automatic logic cond_pass(
    input logic [3:0] cond,
    input logic [3:0] sr
  );
    logic n, z, c, v, p;
    {n, z, c, v} = sr;
    p = 1'b0;
    case (cond)
      COND_EQ: p = z;
      COND_NE: p = ~z;
      COND_CS: p = c;
      COND_CC: p = ~c;
      COND_MI: p = n;
      COND_PL: p = ~n;
      COND_VS: p = v;
      COND_VC: p = ~v;
      COND_HI: p = c & ~z;
      COND_LS: p = ~c | z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = ~z & (n == v);
      COND_LE: p = z | (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic [CTRL_W-1:0] decode_ctrl(
    input logic [1:0] mode,
    input logic [3:0] op,
    input logic       s
  );
    logic [CTRL_W-1:0] c;
    logic [3:0] exe;
    logic wb;
    c = '0;
    exe = '0;
    wb = 1'b1;
    unique case (1'b1)
      mode == MODE_ARITH: begin
        case (op)
          OP_AND: exe = EXE_AND;
          OP_EOR: exe = EXE_EOR;
          OP_SUB: exe = EXE_SUB;
          OP_ADD: exe = EXE_ADD;
          OP_ADC: exe = EXE_ADC;
          OP_SBC: exe = EXE_SBC;
          OP_ORR: exe = EXE_ORR;
          OP_MOV: exe = EXE_MOV;
          OP_MVN: exe = EXE_MVN;
          OP_TST: begin exe = EXE_AND; wb = 1'b0; end
          OP_CMP: begin exe = EXE_SUB; wb = 1'b0; end
          default: exe = '0;
        endcase
        if (exe != '0) begin
          c[CTRL_WB_EN] = wb;
          c[CTRL_EXE_HI:CTRL_EXE_LO] = exe;
          c[CTRL_S] = s;
        end
      end
      mode == MODE_MEM: begin
        c[CTRL_EXE_HI:CTRL_EXE_LO] = EXE_ADD;
        if (s) begin
          c[CTRL_WB_EN] = 1'b1;
          c[CTRL_MEM_R] = 1'b1;
        end else begin
          c[CTRL_MEM_W] = 1'b1;
        end
      end
      mode == MODE_BR: c[CTRL_B] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: async reset, one write port, two read ports
// with same-cycle write-back bypass.
module id_regfile #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr1,
  input  logic [RA_W-1:0]   raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import id_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register, hazard stall and stall counter.
// Define ID_FWD_EN when EX forwards results; only load-use then stalls.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_W = 32,
  parameter int CTRL_W = 9,
  parameter int STALL_CNT_W = 16,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [3:0]             sr,
  input  logic                   wb_en,
  input  logic [RA_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]      wb_value,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r,
  input  logic [RA_W-1:0]        exe_dest,
  input  logic                   mem_wb_en,
  input  logic [RA_W-1:0]        mem_dest,
  input  logic                   ex_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [PC_W-1:0]        out_pc,
  output logic [DATA_W-1:0]      out_val_rn,
  output logic [DATA_W-1:0]      out_val_rm,
  output logic [RA_W-1:0]        out_src1,
  output logic [RA_W-1:0]        out_src2,
  output logic [RA_W-1:0]        out_dest,
  output logic                   out_imm,
  output logic [11:0]            out_shift_operand,
  output logic [23:0]            out_signed_imm_24,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_count
);
  import id_pkg::*;

  logic [CTRL_W-1:0] ctrl;
  logic [RA_W-1:0]   src1;
  logic [RA_W-1:0]   src2;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              use1;
  logic              use2;
  logic              hit_exe;
  logic              hit_mem;

  // A failed condition turns the instruction into a bubble.
  always_comb begin
    ctrl = '0;
    if (cond_pass(instruction[31:28], sr))
      ctrl = decode_ctrl(instruction[27:26],
                         instruction[24:21],
                         instruction[20]);
  end

  assign src1 = instruction[16 +: RA_W];
  assign src2 = ctrl[CTRL_MEM_W] ? instruction[12 +: RA_W]
                                 : instruction[0 +: RA_W];

  id_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_dest),
    .wdata  (wb_value),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (val_rn),
    .rdata2 (val_rm)
  );

  assign use1 = ~ctrl[CTRL_B];
  assign use2 = ~ctrl[CTRL_B] &
                (~instruction[25] | ctrl[CTRL_MEM_W]);

  assign hit_exe = (use1 && exe_dest == src1) ||
                   (use2 && exe_dest == src2);
  assign hit_mem = (use1 && mem_dest == src1) ||
                   (use2 && mem_dest == src2);

`ifdef ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = mem_wb_en ^ hit_mem;
  assign hazard = in_valid & (|ctrl) &
                  exe_wb_en & exe_mem_r & hit_exe;
`else
  logic unused_fwd;
  assign unused_fwd = exe_mem_r;
  assign hazard = in_valid & (|ctrl) &
                  ((exe_wb_en & hit_exe) |
                   (mem_wb_en & hit_mem));
`endif

  assign in_ready = ex_ready & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_ctrl          <= '0;
      out_pc            <= '0;
      out_val_rn        <= '0;
      out_val_rm        <= '0;
      out_src1          <= '0;
      out_src2          <= '0;
      out_dest          <= '0;
      out_imm           <= 1'b0;
      out_shift_operand <= '0;
      out_signed_imm_24 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (ex_ready) begin
      if (in_valid && !hazard) begin
        out_valid         <= 1'b1;
        out_ctrl          <= ctrl;
        out_pc            <= pc_in;
        out_val_rn        <= val_rn;
        out_val_rm        <= val_rm;
        out_src1          <= src1;
        out_src2          <= src2;
        out_dest          <= instruction[12 +: RA_W];
        out_imm           <= instruction[25];
        out_shift_operand <= instruction[11:0];
        out_signed_imm_24 <= instruction[23:0];
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (in_valid && !in_ready && !flush && !(&stall_count))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: behavioural model compared
// every cycle plus directed literal expectations.
module tb_id_stage_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic [3:0]  sr;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en;
  logic        exe_mem_r;
  logic [3:0]  exe_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        ex_ready;
  logic        flush;
  logic        out_valid;
  logic [8:0]  out_ctrl;
  logic [31:0] out_pc;
  logic [31:0] out_val_rn;
  logic [31:0] out_val_rm;
  logic [3:0]  out_src1;
  logic [3:0]  out_src2;
  logic [3:0]  out_dest;
  logic        out_imm;
  logic [11:0] out_shift_operand;
  logic [23:0] out_signed_imm_24;
  logic        hazard;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_stage_pipe dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instruction       (instruction),
    .pc_in             (pc_in),
    .sr                (sr),
    .wb_en             (wb_en),
    .wb_dest           (wb_dest),
    .wb_value          (wb_value),
    .exe_wb_en         (exe_wb_en),
    .exe_mem_r         (exe_mem_r),
    .exe_dest          (exe_dest),
    .mem_wb_en         (mem_wb_en),
    .mem_dest          (mem_dest),
    .ex_ready          (ex_ready),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ctrl          (out_ctrl),
    .out_pc            (out_pc),
    .out_val_rn        (out_val_rn),
    .out_val_rm        (out_val_rm),
    .out_src1          (out_src1),
    .out_src2          (out_src2),
    .out_dest          (out_dest),
    .out_imm           (out_imm),
    .out_shift_operand (out_shift_operand),
    .out_signed_imm_24 (out_signed_imm_24),
    .hazard            (hazard),
    .stall_count       (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [16];
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [31:0] m_pc, m_rn, m_rm;
  logic [3:0]  m_s1, m_s2, m_dest;
  logic        m_imm;
  logic [11:0] m_sh;
  logic [23:0] m_si;
  logic [15:0] m_stall;
  logic        m_known;

  // Classic ARM form: even code tests a predicate, odd code its inverse.
  function automatic logic m_cond(input logic [3:0] c,
                                  input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hf) return 1'b0;
    if (c == 4'he) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [8:0] m_decode(input logic [31:0] i,
                                          input logic [3:0] f);
    logic [3:0] exe;
    logic wb;
    exe = 4'd0;
    wb = 1'b1;
    if (!m_cond(i[31:28], f)) return 9'd0;
    if (i[27:26] == 2'b10) return 9'd2;
    if (i[27:26] == 2'b01)
      return i[20] ? 9'b1_1_0_0010_0_0 : 9'b0_0_1_0010_0_0;
    if (i[27:26] != 2'b00) return 9'd0;
    case (i[24:21])
      4'd0:  exe = 4'd6;
      4'd1:  exe = 4'd8;
      4'd2:  exe = 4'd4;
      4'd4:  exe = 4'd2;
      4'd5:  exe = 4'd3;
      4'd6:  exe = 4'd5;
      4'd8:  begin exe = 4'd6; wb = 1'b0; end
      4'd10: begin exe = 4'd4; wb = 1'b0; end
      4'd12: exe = 4'd7;
      4'd13: exe = 4'd1;
      4'd15: exe = 4'd9;
      default: return 9'd0;
    endcase
    return {wb, 2'b00, exe, 1'b0, i[20]};
  endfunction

  function automatic logic [3:0] m_src2(input logic [31:0] i,
                                        input logic [8:0] c);
    return c[6] ? i[15:12] : i[3:0];
  endfunction

  function automatic logic m_hit(input logic [3:0] d,
                                 input logic [31:0] i,
                                 input logic [8:0] c);
    logic u1, u2;
    u1 = !c[1];
    u2 = !c[1] && (!i[25] || c[6]);
    return (u1 && d == i[19:16]) || (u2 && d == m_src2(i, c));
  endfunction

  function automatic logic m_hazard();
    logic [8:0] c;
    c = m_decode(instruction, sr);
    if (!in_valid || c == 9'd0) return 1'b0;
`ifdef ID_FWD_EN
    return exe_wb_en && exe_mem_r && m_hit(exe_dest, instruction, c);
`else
    return (exe_wb_en && m_hit(exe_dest, instruction, c)) ||
           (mem_wb_en && m_hit(mem_dest, instruction, c));
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    return (wb_en && wb_dest == idx) ? wb_value : m_rf[idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) m_rf[k] <= 32'd0;
      m_valid <= 1'b0; m_ctrl <= 9'd0; m_pc <= 32'd0;
      m_rn <= 32'd0; m_rm <= 32'd0; m_s1 <= 4'd0; m_s2 <= 4'd0;
      m_dest <= 4'd0; m_imm <= 1'b0; m_sh <= 12'd0; m_si <= 24'd0;
      m_stall <= 16'd0; m_known <= 1'b1;
    end else begin
      if (in_valid && !(ex_ready && !m_hazard()) && !flush &&
          m_stall != 16'hffff)
        m_stall <= m_stall + 16'd1;
      if (flush) begin
        m_valid <= 1'b0; m_ctrl <= 9'd0; m_known <= 1'b0;
      end else if (!ex_ready) begin
        m_valid <= m_valid;
      end else if (in_valid && !m_hazard()) begin
        m_valid <= 1'b1;
        m_ctrl  <= m_decode(instruction, sr);
        m_pc    <= pc_in;
        m_s1    <= instruction[19:16];
        m_s2    <= m_src2(instruction, m_decode(instruction, sr));
        m_rn    <= m_read(instruction[19:16]);
        m_rm    <= m_read(m_src2(instruction, m_decode(instruction, sr)));
        m_dest  <= instruction[15:12];
        m_imm   <= instruction[25];
        m_sh    <= instruction[11:0];
        m_si    <= instruction[23:0];
        m_known <= 1'b1;
      end else begin
        m_valid <= 1'b0; m_ctrl <= 9'd0; m_known <= 1'b0;
      end
      if (wb_en) m_rf[wb_dest] <= wb_value;
    end
  end

  always @(negedge clk) begin
    check("m_valid", 64'(out_valid), 64'(m_valid));
    check("m_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    check("m_hazard", 64'(hazard), 64'(m_hazard()));
    check("m_in_ready", 64'(in_ready), 64'(ex_ready && !m_hazard()));
    check("m_stall", 64'(stall_count), 64'(m_stall));
    if (m_known) begin
      check("m_pc", 64'(out_pc), 64'(m_pc));
      check("m_rn", 64'(out_val_rn), 64'(m_rn));
      check("m_rm", 64'(out_val_rm), 64'(m_rm));
      check("m_src1", 64'(out_src1), 64'(m_s1));
      check("m_src2", 64'(out_src2), 64'(m_s2));
      check("m_dest", 64'(out_dest), 64'(m_dest));
      check("m_imm", 64'(out_imm), 64'(m_imm));
      check("m_shift", 64'(out_shift_operand), 64'(m_sh));
      check("m_simm", 64'(out_signed_imm_24), 64'(m_si));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hz_vec(input string name, input logic [31:0] ins,
                        input logic ew, input logic emr,
                        input logic [3:0] ed, input logic mw,
                        input logic [3:0] md, input logic exp_def,
                        input logic exp_fwd);
    instruction = ins; exe_wb_en = ew; exe_mem_r = emr;
    exe_dest = ed; mem_wb_en = mw; mem_dest = md;
    #1;
`ifdef ID_FWD_EN
    check(name, 64'(hazard), 64'(exp_fwd));
`else
    check(name, 64'(hazard), 64'(exp_def));
`endif
    tick();
  endtask

  localparam logic [31:0] ADD_R1_R2_R3 = 32'hE082_1003;
  localparam logic [31:0] ADDEQ        = 32'h0082_1003;
  localparam logic [31:0] ADD_R3_R4_R5 = 32'hE084_3005;
  localparam logic [31:0] ADD_IMM      = 32'hE282_1003;
  localparam logic [31:0] STR_R3_R2    = 32'hE582_3000;
  localparam logic [31:0] BRANCH       = 32'hEA00_0010;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = 32'd0; pc_in = 32'd0;
    sr = 4'd0; wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0;
    exe_wb_en = 1'b0; exe_mem_r = 1'b0; exe_dest = 4'd0;
    mem_wb_en = 1'b0; mem_dest = 4'd0; ex_ready = 1'b1; flush = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    rst = 1'b0;

    // write R3 while decoding an instruction that reads it
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h0000_00AA;
    instruction = ADD_R1_R2_R3; pc_in = 32'h100; in_valid = 1'b1;
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_rm", 64'(out_val_rm), 64'hAA);
    check("t1_ctrl", 64'(out_ctrl), 64'h108);
    check("t1_src1", 64'(out_src1), 64'd2);
    check("t1_src2", 64'(out_src2), 64'd3);
    check("t1_dest", 64'(out_dest), 64'd1);
    wb_en = 1'b0;

    // condition EQ fails with Z=0: consumed as a bubble
    instruction = ADDEQ; pc_in = 32'h104; sr = 4'b0000;
    #1;
    check("t2_ready", 64'(in_ready), 64'd1);
    tick();
    check("t2_ctrl", 64'(out_ctrl), 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);

    // RAW on R2 against EX
    instruction = ADD_R1_R2_R3; pc_in = 32'h108;
    exe_wb_en = 1'b1; exe_dest = 4'd2;
    #1;
    check("t3_hazard", 64'(hazard), 64'd1);
    check("t3_ready", 64'(in_ready), 64'd0);
    tick();
    check("t3_bubble", 64'(out_valid), 64'd0);
    exe_wb_en = 1'b0;
    tick();
    check("t3_valid", 64'(out_valid), 64'd1);
    check("t3_pc", 64'(out_pc), 64'h108);
    check("t3_rm", 64'(out_val_rm), 64'hAA);
    check("t3_stall", 64'(stall_count), 64'd1);

    // EX back-pressure holds ID/EX, then flush during the hold
    ex_ready = 1'b0; instruction = ADD_R3_R4_R5; pc_in = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_pc", 64'(out_pc), 64'h108);
    end
    check("t4_stall", 64'(stall_count), 64'd4);
    flush = 1'b1;
    tick();
    check("t4_flush_valid", 64'(out_valid), 64'd0);
    check("t4_flush_ctrl", 64'(out_ctrl), 64'd0);
    check("t4_flush_stall", 64'(stall_count), 64'd4);
    flush = 1'b0; ex_ready = 1'b1;
    tick();
    check("t4_load_pc", 64'(out_pc), 64'h200);
    check("t4_load_dest", 64'(out_dest), 64'd3);

    // hazard rule table: default-build and forwarding-build answers
    pc_in = 32'h300;
    hz_vec("hz_mem_src1", ADD_R1_R2_R3, 0, 0, 4'd0, 1, 4'd2, 1, 0);
    hz_vec("hz_exe_load", ADD_R1_R2_R3, 1, 1, 4'd2, 0, 4'd0, 1, 1);
    hz_vec("hz_exe_src2", ADD_R1_R2_R3, 1, 0, 4'd3, 0, 4'd0, 1, 0);
    hz_vec("hz_imm_nosrc2", ADD_IMM, 1, 1, 4'd3, 0, 4'd0, 0, 0);
    hz_vec("hz_imm_src1", ADD_IMM, 1, 0, 4'd2, 0, 4'd0, 1, 0);
    hz_vec("hz_str_rd", STR_R3_R2, 1, 1, 4'd3, 0, 4'd0, 1, 1);
    hz_vec("hz_branch", BRANCH, 1, 1, 4'd0, 1, 4'd0, 0, 0);
    hz_vec("hz_cond_fail", ADDEQ, 1, 1, 4'd2, 1, 4'd2, 0, 0);
    hz_vec("hz_no_match", ADD_R1_R2_R3, 1, 1, 4'd7, 1, 4'd5, 0, 0);

    // asynchronous reset in the middle of a stall
    hz_vec("t6_stall", ADD_R1_R2_R3, 1, 1, 4'd2, 1, 4'd2, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ctrl", 64'(out_ctrl), 64'd0);
    check("t6_pc", 64'(out_pc), 64'd0);
    check("t6_stall", 64'(stall_count), 64'd0);
    exe_wb_en = 1'b0; exe_mem_r = 1'b0; mem_wb_en = 1'b0;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; instruction = ADD_R1_R2_R3; pc_in = 32'h400;
    tick();
    check("t6_r3_zero", 64'(out_val_rm), 64'd0);
    check("t6_load", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
